// File: rtl/pwm_clkdiv_multi.sv
// Multi-channel programmable clock divider feeding the PWM carrier counters.
// Each channel divides clk by 2*(D+1), emits a one-cycle enable every D+1 cycles, and defers reloads to its terminal count.
module pwm_clkdiv_multi #(
  parameter int NCH       = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCH*DIV_WIDTH-1:0] divider,
  input  logic [NCH-1:0]           load,
  input  logic [NCH-1:0]           ch_enable,
  input  logic [NCH-1:0]           bypass,
  input  logic                     sync_start,
  output logic [NCH-1:0]           div_clk,
  output logic [NCH-1:0]           div_ce,
  output logic [NCH-1:0]           pending
);

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [DIV_WIDTH-1:0] cnt_reg;
      logic [DIV_WIDTH-1:0] div_act_reg;
      logic [DIV_WIDTH-1:0] shadow_reg;
      logic [DIV_WIDTH-1:0] div_new;
      logic                 pending_reg;
      logic                 div_clk_reg;
      logic                 div_ce_reg;
      logic                 running;
      logic                 tc;
      logic                 restart;

      assign div_new = divider[gi*DIV_WIDTH +: DIV_WIDTH];
      assign running = ch_enable[gi] & ~bypass[gi];
      // tc is checked before the increment, so cnt never wraps even at D = all-ones.
      assign tc      = running & (cnt_reg == div_act_reg);
      assign restart = sync_start | tc;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_reg     <= '0;
          div_act_reg <= '0;
          shadow_reg  <= '0;
          pending_reg <= 1'b0;
          div_clk_reg <= 1'b0;
          div_ce_reg  <= 1'b0;
        end else if (!running) begin
          // Stopped or bypassed: no glitch to protect, so loads apply immediately.
          cnt_reg     <= '0;
          div_clk_reg <= 1'b0;
          div_ce_reg  <= 1'b0;
          if (load[gi]) begin
            div_act_reg <= div_new;
            pending_reg <= 1'b0;
          end
        end else if (restart) begin
          cnt_reg     <= '0;
          div_clk_reg <= sync_start ? 1'b0 : ~div_clk_reg;
          div_ce_reg  <= ~sync_start;
          if (load[gi]) begin
            div_act_reg <= div_new;
            pending_reg <= 1'b0;
          end else if (pending_reg) begin
            div_act_reg <= shadow_reg;
            pending_reg <= 1'b0;
          end
        end else begin
          cnt_reg    <= cnt_reg + 1'b1;
          div_ce_reg <= 1'b0;
          if (load[gi]) begin
            shadow_reg  <= div_new;
            pending_reg <= 1'b1;
          end
        end
      end

      assign div_clk[gi] = bypass[gi] ? (ch_enable[gi] & clk) : div_clk_reg;
      assign div_ce[gi]  = bypass[gi] ? ch_enable[gi] : div_ce_reg;
      assign pending[gi] = pending_reg;
    end
  endgenerate

endmodule
